// File: rtl/multiplication.sv
// Bit-serial shift-and-add multiplier rebuilding a Q12.11 product from a Q9.11 operand and a 3-bit integer.
// Optional MULTIPLICATION_EARLY_TERM_EN stops accumulating once no set bits remain in the serial operand.
module multiplication #(
  parameter int WIDTH_A = 20,
  parameter int WIDTH_B = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH_A-1:0]         in_data_1,
  input  logic [WIDTH_B-1:0]         in_data_2,
  output logic                       out_valid,
  output logic [WIDTH_A+WIDTH_B-1:0] out_data
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int CW = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH_A - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH_A-1:0] a_reg;
  logic [PW-1:0]      b_sh;
  logic [PW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      next_acc;
  logic               last;

  // Partial product for one serial bit: the shifted multiplicand or nothing.
  function automatic logic [PW-1:0] partial(input logic sel, input logic [PW-1:0] addend);
    return sel ? addend : '0;
  endfunction

  always_comb begin
    next_acc = acc + partial(a_reg[0], b_sh);
`ifdef MULTIPLICATION_EARLY_TERM_EN
    last = (cnt == LAST_BIT) || (a_reg[WIDTH_A-1:1] == '0);
`else
    last = (cnt == LAST_BIT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_data_1;
            b_sh  <= {{WIDTH_A{1'b0}}, in_data_2};
            state <= LOAD;
          end
        end
        LOAD: begin
          // Keep recapturing while framing lasts so the final pair wins.
          if (in_valid) begin
            a_reg <= in_data_1;
            b_sh  <= {{WIDTH_A{1'b0}}, in_data_2};
          end else begin
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc   <= next_acc;
          a_reg <= a_reg >> 1;
          b_sh  <= b_sh << 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            out_data  <= next_acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_data  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the bit-serial multiplier: products, strobe latency, framing and reset abort.
module tb_multiplication;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data_1 = '0;
  logic [2:0]  in_data_2 = '0;
  logic        out_valid;
  logic [22:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MULTIPLICATION_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  multiplication #(.WIDTH_A(20), .WIDTH_B(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data_1(in_data_1),
    .in_data_2(in_data_2),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair for a single cycle, then drop framing through edge k.
  task automatic start(input logic [19:0] a, input logic [2:0] b);
    in_valid  = 1'b1;
    in_data_1 = a;
    in_data_2 = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  // Called right after edge k; optionally pulses in_valid with (0xFFFFF,7) before edge k+pulse_at+1.
  task automatic wait_result(input string tag, input logic [22:0] exp,
                             input int lat_full, input int lat_early, input int pulse_at);
    int n;
    int lat;
    bit seen;
    bit stray;
    lat   = EARLY ? lat_early : lat_full;
    n     = 0;
    seen  = 1'b0;
    stray = 1'b0;
    while (!seen && n < 40) begin
      if (n == pulse_at) begin
        in_valid  = 1'b1;
        in_data_1 = 20'hFFFFF;
        in_data_2 = 3'd7;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n++;
      if (out_valid) seen = 1'b1;
      else if (out_data != '0) stray = 1'b1;
    end
    in_valid = 1'b0;
    check({tag, " strobe"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " data"}, 32'(out_data), 32'(exp));
    check({tag, " data before strobe"}, 32'(stray), 32'd0);
    tick();
    check({tag, " strobe fall"}, 32'(out_valid), 32'd0);
    check({tag, " data cleared"}, 32'(out_data), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid) hit = 1'b1;
    end
    check(tag, 32'(hit), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    start(20'h00800, 3'd5);
    wait_result("one_x5", 23'h002800, 20, 12, -1);

    start(20'hFFFFF, 3'd7);
    wait_result("max_x7", 23'h6FFFF9, 20, 20, -1);

    start(20'h12345, 3'd0);
    wait_result("b_zero", 23'h000000, 20, 17, -1);

    start(20'h00000, 3'd3);
    wait_result("a_zero", 23'h000000, 20, 1, -1);

    // Three framed cycles: only the last pair may be used.
    in_valid = 1'b1; in_data_1 = 20'h00400; in_data_2 = 3'd2; tick();
    in_data_1 = 20'h00C00; in_data_2 = 3'd3; tick();
    in_data_1 = 20'h01000; in_data_2 = 3'd4; tick();
    in_valid = 1'b0; tick();
    wait_result("last_wins", 23'h004000, 20, 13, -1);

    start(20'h00800, 3'd1);
    wait_result("mul_pulse", 23'h000800, 20, 12, 3);
    in_data_1 = '0;
    in_data_2 = '0;
    expect_quiet("pulse not queued", 30);

    // Abort mid-MUL: reset asserted between edges k+9 and k+10, held across k+10.
    start(20'h00800, 3'd5);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("abort no strobe", 30);

    start(20'h00200, 3'd6);
    wait_result("after_abort", 23'h000C00, 20, 10, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
